// File: rtl/game_ctrl_core.sv
// Game controller core: synchronised button edges, game-mode FSM, gravity-flip player physics
// and a one-slot-per-cycle obstacle collision scan that runs after every frame's physics update.
module game_ctrl_core #(
   parameter int N_OBS    = 10,
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int PLAYER_X = 100,
   parameter int PLAYER_W = 16,
   parameter int PLAYER_H = 16,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 463,
   parameter int Y_START  = 240,
   parameter int GRAV     = 1,
   parameter int V_MAX    = 8,
   parameter int SCORE_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [2:0]               btn,
   input  logic [N_OBS*2*X_W-1:0]   obstacle_x,
   input  logic [N_OBS*2*Y_W-1:0]   obstacle_y,
   output logic [1:0]               gamemode,
   output logic [Y_W-1:0]           player_y,
   output logic [SCORE_W-1:0]       score,
   output logic                     hit
);

   localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
   localparam int S_W   = Y_W + 2;

   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_OBS - 1);
   localparam logic [X_W-1:0]       PX_LO    = X_W'(PLAYER_X);
   localparam logic [X_W-1:0]       PX_HI    = X_W'(PLAYER_X + PLAYER_W - 1);
   localparam logic [Y_W:0]         PH_OFS   = (Y_W+1)'(PLAYER_H - 1);
   localparam logic signed [S_W-1:0] GRAV_S  = S_W'(GRAV);
   localparam logic signed [S_W-1:0] VMAX_S  = S_W'(V_MAX);
   localparam logic signed [S_W-1:0] YMIN_S  = S_W'(Y_MIN);
   localparam logic signed [S_W-1:0] YMAX_S  = S_W'(Y_MAX);

   typedef enum logic [1:0] {
      MODE_INIT  = 2'b00,
      MODE_PLAY  = 2'b01,
      MODE_PAUSE = 2'b10,
      MODE_ENDED = 2'b11
   } mode_t;

   mode_t mode, mode_next;

   logic [2:0] sync1, sync2, btn_prev, btn_edge;
   logic       b0_act, playing, restart, abort, do_phys, frame_hit, frame_clear;

   logic                    scan_busy, scan_done, hit_acc, slot_hit;
   logic [IDX_W-1:0]        scan_idx;
   logic [X_W-1:0]          lefts [N_OBS];
   logic [X_W-1:0]          rights [N_OBS];
   logic [Y_W-1:0]          tops [N_OBS];
   logic [Y_W-1:0]          bottoms [N_OBS];
   logic [X_W-1:0]          slot_left, slot_right;
   logic [Y_W-1:0]          slot_top, slot_bot;
   logic [Y_W:0]            y_hi;

   logic                    grav_up;
   logic signed [S_W-1:0]   vel, vel_step, vel_clamped, y_sum, vel_upd;
   logic [Y_W-1:0]          y_upd;

   // Two-flop synchroniser plus a third flop so each press yields exactly one edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         btn_prev <= '0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         btn_prev <= sync2;
      end
   end

   assign btn_edge = sync2 & ~btn_prev;
   assign b0_act   = btn_edge[0] & ~btn_edge[1] & ~btn_edge[2];

   assign restart     = btn_edge[2] | (btn_edge[1] & ((mode == MODE_INIT) | (mode == MODE_ENDED)));
   assign abort       = btn_edge[2] | btn_edge[1];
   assign do_phys     = tick & playing & ~scan_busy & ~scan_done & ~abort;
   assign frame_hit   = scan_done & hit_acc & ~abort;
   assign frame_clear = scan_done & ~hit_acc & ~abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mode <= MODE_INIT;
      else     mode <= mode_next;
   end

   always_comb begin
      mode_next = mode;
      if (btn_edge[2]) begin
         mode_next = MODE_INIT;
      end else if (btn_edge[1]) begin
         unique case (mode)
            MODE_INIT:  mode_next = MODE_PLAY;
            MODE_PLAY:  mode_next = MODE_PAUSE;
            MODE_PAUSE: mode_next = MODE_PLAY;
            MODE_ENDED: mode_next = MODE_PLAY;
            default:    mode_next = MODE_INIT;
         endcase
      end else if (frame_hit) begin
         mode_next = MODE_ENDED;
      end
   end

   always_comb begin
      gamemode = mode;
      playing  = (mode == MODE_PLAY);
   end

   // Velocity is clamped before it moves the player; touching either bound kills the velocity.
   always_comb begin
      vel_step = grav_up ? (vel - GRAV_S) : (vel + GRAV_S);
      if (vel_step > VMAX_S)       vel_clamped = VMAX_S;
      else if (vel_step < -VMAX_S) vel_clamped = -VMAX_S;
      else                         vel_clamped = vel_step;
      y_sum   = $signed({2'b00, player_y}) + vel_clamped;
      vel_upd = vel_clamped;
      y_upd   = y_sum[Y_W-1:0];
      if (y_sum < YMIN_S) begin
         y_upd   = Y_W'(Y_MIN);
         vel_upd = '0;
      end else if (y_sum > YMAX_S) begin
         y_upd   = Y_W'(Y_MAX);
         vel_upd = '0;
      end
   end

   for (genvar i = 0; i < N_OBS; i++) begin : g_unpack
      assign lefts[i]   = obstacle_x[2*i*X_W +: X_W];
      assign rights[i]  = obstacle_x[(2*i+1)*X_W +: X_W];
      assign tops[i]    = obstacle_y[2*i*Y_W +: Y_W];
      assign bottoms[i] = obstacle_y[(2*i+1)*Y_W +: Y_W];
   end

   // A single comparator set is shared across slots; left > right marks an empty slot.
   always_comb begin
      slot_left  = lefts[scan_idx];
      slot_right = rights[scan_idx];
      slot_top   = tops[scan_idx];
      slot_bot   = bottoms[scan_idx];
      y_hi       = {1'b0, player_y} + PH_OFS;
      slot_hit   = (slot_left <= slot_right) &&
                   (slot_left <= PX_HI) && (slot_right >= PX_LO) &&
                   ({1'b0, slot_top} <= y_hi) && (slot_bot >= player_y);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_busy <= 1'b0;
         scan_done <= 1'b0;
         scan_idx  <= '0;
         hit_acc   <= 1'b0;
      end else if (abort) begin
         scan_busy <= 1'b0;
         scan_done <= 1'b0;
         scan_idx  <= '0;
         hit_acc   <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         if (do_phys) begin
            scan_busy <= 1'b1;
            scan_idx  <= '0;
            hit_acc   <= 1'b0;
         end else if (scan_busy) begin
            hit_acc <= hit_acc | slot_hit;
            if (scan_idx == LAST_IDX) begin
               scan_busy <= 1'b0;
               scan_done <= 1'b1;
            end else begin
               scan_idx <= scan_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         player_y <= Y_W'(Y_START);
         vel      <= '0;
         grav_up  <= 1'b0;
         score    <= '0;
         hit      <= 1'b0;
      end else begin
         hit <= frame_hit;
         if (restart) begin
            player_y <= Y_W'(Y_START);
            vel      <= '0;
            grav_up  <= 1'b0;
            score    <= '0;
         end else begin
            if (b0_act && playing) grav_up <= ~grav_up;
            if (do_phys) begin
               vel      <= vel_upd;
               player_y <= y_upd;
            end
            if (frame_clear && (score != '1)) score <= score + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_game_ctrl_core.sv
// Scoreboard bench for game_ctrl_core: a behavioural model pushes expected values when stimulus
// is driven, and they are popped and compared once the DUT output is due.
module tb_game_ctrl_core;

   localparam int N_OBS = 10;
   localparam int X_W   = 10;
   localparam int Y_W   = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst, tick, tick2;
   logic [2:0]             btn, btn2;
   logic [N_OBS*2*X_W-1:0] obstacle_x, obs2_x;
   logic [N_OBS*2*Y_W-1:0] obstacle_y, obs2_y;
   logic [1:0]             gamemode, gamemode2;
   logic [Y_W-1:0]         player_y, player_y2;
   logic [15:0]            score;
   logic [3:0]             score2;
   logic                   hit, hit2;

   game_ctrl_core dut (
      .clk(clk), .rst(rst), .tick(tick), .btn(btn),
      .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
      .gamemode(gamemode), .player_y(player_y), .score(score), .hit(hit)
   );

   // Narrow score counter so saturation is reachable in a short run.
   game_ctrl_core #(.SCORE_W(4)) dut2 (
      .clk(clk), .rst(rst), .tick(tick2), .btn(btn2),
      .obstacle_x(obs2_x), .obstacle_y(obs2_y),
      .gamemode(gamemode2), .player_y(player_y2), .score(score2), .hit(hit2)
   );

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   int   m_y, m_vel, m_score, m_mode;
   bit   m_up;
   int   sl[N_OBS], sr[N_OBS], st[N_OBS], sbot[N_OBS];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setSlot(input int i, input int l, input int r, input int t, input int b);
      sl[i] = l; sr[i] = r; st[i] = t; sbot[i] = b;
      obstacle_x[2*i*X_W +: X_W]     = X_W'(l);
      obstacle_x[(2*i+1)*X_W +: X_W] = X_W'(r);
      obstacle_y[2*i*Y_W +: Y_W]     = Y_W'(t);
      obstacle_y[(2*i+1)*Y_W +: Y_W] = Y_W'(b);
   endtask

   // Empty slot that would overlap the player if the left>right rule were ignored.
   task automatic clearSlot(input int i);
      setSlot(i, 110, 105, 0, 500);
   endtask

   function automatic bit modelCollide(input int y);
      bit c = 0;
      for (int i = 0; i < N_OBS; i++)
         if (sl[i] <= sr[i] && sl[i] <= 115 && sr[i] >= 100 && st[i] <= y + 15 && sbot[i] >= y)
            c = 1;
      return c;
   endfunction

   task automatic modelPhysics();
      int ny;
      m_vel = m_vel + (m_up ? -1 : 1);
      if (m_vel > 8)  m_vel = 8;
      if (m_vel < -8) m_vel = -8;
      ny = m_y + m_vel;
      if (ny < 0)        begin ny = 0;   m_vel = 0; end
      else if (ny > 463) begin ny = 463; m_vel = 0; end
      m_y = ny;
   endtask

   task automatic modelRestart();
      m_y = 240; m_vel = 0; m_up = 0; m_score = 0;
   endtask

   task automatic pushExp(input string tag, input int kind, input int exp);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = 32'(exp);
      sb.push_back(e);
   endtask

   task automatic popCheck();
      exp_t        e;
      logic [31:0] obs;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL sb_empty: got 0 entries, expected at least 1");
      end else begin
         e = sb.pop_front();
         case (e.kind)
            0:       obs = 32'(player_y);
            1:       obs = 32'(score);
            2:       obs = 32'(gamemode);
            default: obs = 32'(hit);
         endcase
         checkOutput(e.tag, obs, e.exp);
      end
   endtask

   // One frame: tick pulse, physics visible next cycle, scan result N_OBS+2 cycles after the tick.
   task automatic applyStimulus(input string name);
      bit exp_hit;
      modelPhysics();
      exp_hit = modelCollide(m_y);
      pushExp({name, "_y"}, 0, m_y);
      if (exp_hit) m_mode = 3;
      else if (m_score < 65535) m_score++;
      pushExp({name, "_hit"}, 3, int'(exp_hit));
      pushExp({name, "_mode"}, 2, m_mode);
      pushExp({name, "_score"}, 1, m_score);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      popCheck();
      cyc(10);
      checkOutput({name, "_hit_early"}, 32'(hit), 0);
      cyc(1);
      popCheck(); popCheck(); popCheck();
      cyc(1);
      checkOutput({name, "_hit_end"}, 32'(hit), 0);
   endtask

   task automatic pressButton(input logic [2:0] mask, input string name);
      int old_mode = m_mode;
      if (mask[2]) begin
         m_mode = 0; modelRestart();
      end else if (mask[1]) begin
         if (old_mode == 0 || old_mode == 3) begin m_mode = 1; modelRestart(); end
         else if (old_mode == 1) m_mode = 2;
         else m_mode = 1;
      end else if (mask[0] && old_mode == 1) begin
         m_up = ~m_up;
      end
      pushExp({name, "_mode"}, 2, m_mode);
      pushExp({name, "_y"}, 0, m_y);
      pushExp({name, "_score"}, 1, m_score);
      btn = mask;
      cyc(2);
      checkOutput({name, "_pre"}, 32'(gamemode), 32'(old_mode));
      cyc(1);
      popCheck(); popCheck(); popCheck();
      cyc(2);
      btn = 3'b000;
      cyc(3);
      checkOutput({name, "_held"}, 32'(gamemode), 32'(m_mode));
   endtask

   initial begin
      bit seen_hit;
      int s2;
      rst = 1'b1; tick = 1'b0; tick2 = 1'b0; btn = '0; btn2 = '0;
      obstacle_x = '0; obstacle_y = '0;
      for (int i = 0; i < N_OBS; i++) clearSlot(i);
      obs2_x = obstacle_x;
      obs2_y = obstacle_y;
      m_mode = 0; modelRestart();
      cyc(3);
      checkOutput("rst_mode", 32'(gamemode), 0);
      checkOutput("rst_y", 32'(player_y), 240);
      checkOutput("rst_score", 32'(score), 0);
      checkOutput("rst_hit", 32'(hit), 0);
      rst = 1'b0;
      cyc(2);

      $display("[TB] start and free fall");
      pressButton(3'b010, "start");
      for (int k = 0; k < 5; k++) applyStimulus("fall5");
      checkOutput("fall5_y255", 32'(player_y), 255);

      $display("[TB] floor and ceiling clamps");
      for (int k = 0; k < 100 && m_y < 463; k++) applyStimulus("fall");
      applyStimulus("floor");
      pressButton(3'b001, "flip");
      applyStimulus("rise1");
      applyStimulus("rise2");
      for (int k = 0; k < 200 && m_y > 0; k++) applyStimulus("rise");
      applyStimulus("ceiling");

      $display("[TB] collision on last slot");
      pressButton(3'b100, "end_btn");
      pressButton(3'b010, "start2");
      setSlot(9, 95, 120, 230, 260);
      applyStimulus("collide");

      $display("[TB] pause mid-scan");
      pressButton(3'b010, "restart");
      modelPhysics();
      pushExp("pause_y", 0, m_y);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      popCheck();
      btn = 3'b010;
      cyc(2);
      checkOutput("pause_pre", 32'(gamemode), 1);
      cyc(1);
      m_mode = 2;
      checkOutput("pause_mode", 32'(gamemode), 2);
      btn = 3'b000;
      seen_hit = 0;
      repeat (12) begin
         cyc(1);
         if (hit) seen_hit = 1;
      end
      checkOutput("pause_no_hit", 32'(seen_hit), 0);
      checkOutput("pause_score", 32'(score), 32'(m_score));
      checkOutput("pause_hold", 32'(gamemode), 2);
      pressButton(3'b010, "resume");
      clearSlot(9);
      applyStimulus("after_resume");

      $display("[TB] simultaneous start and end buttons");
      pressButton(3'b110, "b1b2");

      $display("[TB] score saturation");
      btn2 = 3'b010;
      cyc(3);
      btn2 = 3'b000;
      cyc(2);
      checkOutput("sat_mode", 32'(gamemode2), 1);
      s2 = 0;
      for (int k = 0; k < 18; k++) begin
         tick2 = 1'b1;
         cyc(1);
         tick2 = 1'b0;
         cyc(12);
         if (s2 < 15) s2++;
         checkOutput("sat_score", 32'(score2), 32'(s2));
      end
      checkOutput("sat_no_hit", 32'(gamemode2), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
